accumulate_scan: RTL and testbench

//  Parametrised array accumulator: from start index init_i to DEPTH-1, adds each element of an
//  on-chip signed array to a running sum seeded by init_acc. Mode selects reduce, inclusive scan
//  or exclusive scan (scan modes write back in place). A host side-port loads/inspects the array.

---
 rtl/accumulate_pkg.sv | 25 ++
 rtl/accumulate_scan_mem.sv | 34 +++
 rtl/accumulate_scan.sv | 154 +++++++++++++++
 tb/tb_accumulate_scan.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/accumulate_pkg.sv
// rtl/accumulate_pkg.sv - shared types for the array accumulate/scan engine
package accumulate_pkg;

  // Operating modes; encoding 3 is reserved and behaves as a plain reduce
  typedef enum logic [1:0] {
    MODE_REDUCE = 2'd0,
    MODE_INCL   = 2'd1,
    MODE_EXCL   = 2'd2
  } mode_e;

  // Engine sequencing: one element takes RD -> ACC -> WR
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    ACC  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  // Scan modes write every visited element back; reduce leaves the array untouched
  function automatic logic mode_writes_back(input logic [1:0] m);
    return (m == MODE_INCL) || (m == MODE_EXCL);
  endfunction

endpackage

// File: rtl/accumulate_scan_mem.sv
// rtl/accumulate_scan_mem.sv - single-port synchronous RAM, registered read address, write-first
module accumulate_scan_mem #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  raddr_q;
  logic              in_range;

  // Addresses past the last entry never write; the engine never issues them
  assign in_range = 32'(addr_i) < 32'(DEPTH);

  // Write the array and capture the read address; reading mem_q through the
  // registered address makes a write visible to the read on the next cycle
  always_ff @(posedge clk) begin
    if (we_i && in_range) begin
      mem_q[addr_i[IDX_W-1:0]] <= wdata_i;
    end
    raddr_q <= addr_i[IDX_W-1:0];
  end

  assign rdata_o = mem_q[raddr_q];

endmodule

// File: rtl/accumulate_scan.sv
// rtl/accumulate_scan.sv - array reduce / inclusive scan / exclusive scan engine with host port
module accumulate_scan
  import accumulate_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_enable,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [DATA_W-1:0] init_acc,
  input  logic [1:0]        mode,
  input  logic              controlArr,
  input  logic              controlArrWEnable_a,
  input  logic [ADDR_W-1:0] controlArrAddr_a,
  input  logic [DATA_W-1:0] controlArrWData_a,
  output logic [DATA_W-1:0] controlArrRData_a,
  output logic              w_enable,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [1:0]        mode_q, mode_d;
  logic              w_enable_q, w_enable_d;
  logic              overflow_q, overflow_d;

  logic              fsm_we;
  logic [DATA_W-1:0] fsm_wdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Host owns the RAM outright while controlArr is high; otherwise the engine drives it
  always_comb begin
    mem_we    = controlArr ? controlArrWEnable_a : fsm_we;
    mem_addr  = controlArr ? controlArrAddr_a    : i_q;
    mem_wdata = controlArr ? controlArrWData_a   : fsm_wdata;
  end

  accumulate_scan_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .rdata_o (mem_rdata)
  );

  // Next-state logic: start handling, per-element read/add/writeback, done reporting
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    acc_d      = acc_q;
    sum_d      = sum_q;
    result_d   = result_q;
    mode_d     = mode_q;
    w_enable_d = w_enable_q;
    overflow_d = overflow_q;
    fsm_we     = 1'b0;
    fsm_wdata  = sum_q;

    if (controlArr) begin
      // Frozen; the host moved the read address, so a pending ACC must re-read
      if (state_q == ACC) begin
        state_d = RD;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE) begin
            result_d   = acc_q;
            w_enable_d = 1'b1;
          end
          if (r_enable) begin
            i_d        = init_i;
            acc_d      = init_acc;
            mode_d     = mode;
            w_enable_d = 1'b0;
            overflow_d = 1'b0;
            // A start index past the array has nothing to add: report the seed
            state_d    = (32'(init_i) >= 32'(DEPTH)) ? DONE : RD;
          end
        end
        RD: begin
          state_d = ACC;
        end
        ACC: begin
          sum_d = acc_q + mem_rdata;
          if ((acc_q[DATA_W-1] == mem_rdata[DATA_W-1]) &&
              (sum_d[DATA_W-1] != acc_q[DATA_W-1])) begin
            overflow_d = 1'b1;
          end
          state_d = WR;
        end
        WR: begin
          fsm_we    = mode_writes_back(mode_q);
          fsm_wdata = (mode_q == MODE_EXCL) ? acc_q : sum_q;
          acc_d     = sum_q;
          if (i_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + ADDR_W'(1);
            state_d = RD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers; RAM contents are deliberately left out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      i_q        <= '0;
      acc_q      <= '0;
      sum_q      <= '0;
      result_q   <= '0;
      mode_q     <= MODE_REDUCE;
      w_enable_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      acc_q      <= acc_d;
      sum_q      <= sum_d;
      result_q   <= result_d;
      mode_q     <= mode_d;
      w_enable_q <= w_enable_d;
      overflow_q <= overflow_d;
    end
  end

  assign controlArrRData_a = controlArr ? mem_rdata : {DATA_W{1'bx}};
  assign w_enable          = w_enable_q;
  assign result            = result_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_accumulate_scan.sv
// tb/tb_accumulate_scan.sv - self-checking bench for accumulate_scan
module tb_accumulate_scan;

  localparam int DW = 64;
  localparam int DP = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          r_enable;
  logic [AW-1:0] init_i;
  logic [DW-1:0] init_acc;
  logic [1:0]    mode;
  logic          controlArr;
  logic          controlArrWEnable_a;
  logic [AW-1:0] controlArrAddr_a;
  logic [DW-1:0] controlArrWData_a;
  logic [DW-1:0] controlArrRData_a;
  logic          w_enable;
  logic [DW-1:0] result;
  logic          overflow;

  logic          s_r_enable;
  logic [1:0]    s_init_i;
  logic [7:0]    s_init_acc;
  logic [1:0]    s_mode;
  logic          s_ctl;
  logic          s_we;
  logic [1:0]    s_addr;
  logic [7:0]    s_wdata;
  logic [7:0]    s_rdata;
  logic          s_w_enable;
  logic [7:0]    s_result;
  logic          s_overflow;

  int n_tests;
  int n_fail;

  longint ref_a [DP];
  longint exp_res;
  logic   exp_ovf;
  int     exp_lat;

  always #5 clk = ~clk;

  accumulate_scan #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) u_dut (
    .clk(clk), .rst(rst), .r_enable(r_enable), .init_i(init_i), .init_acc(init_acc),
    .mode(mode), .controlArr(controlArr), .controlArrWEnable_a(controlArrWEnable_a),
    .controlArrAddr_a(controlArrAddr_a), .controlArrWData_a(controlArrWData_a),
    .controlArrRData_a(controlArrRData_a), .w_enable(w_enable), .result(result),
    .overflow(overflow)
  );

  accumulate_scan #(.DATA_W(8), .DEPTH(2), .ADDR_W(2)) u_small (
    .clk(clk), .rst(rst), .r_enable(s_r_enable), .init_i(s_init_i), .init_acc(s_init_acc),
    .mode(s_mode), .controlArr(s_ctl), .controlArrWEnable_a(s_we),
    .controlArrAddr_a(s_addr), .controlArrWData_a(s_wdata),
    .controlArrRData_a(s_rdata), .w_enable(s_w_enable), .result(s_result),
    .overflow(s_overflow)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the array with plain integer arithmetic; overflow is a
  // 65-bit true sum that disagrees with the 64-bit wrapped sum
  task automatic model_run(input int ii, input longint acc0, input logic [1:0] m);
    longint acc;
    longint s;
    logic signed [64:0] wide;
    acc     = acc0;
    exp_ovf = 1'b0;
    exp_lat = (ii >= DP) ? 1 : 3 * (DP - ii) + 1;
    for (int k = ii; k < DP; k++) begin
      s    = acc + ref_a[k];
      wide = 65'(acc) + 65'(ref_a[k]);
      if (wide != 65'(s)) exp_ovf = 1'b1;
      if (m == 2'd1) ref_a[k] = s;
      else if (m == 2'd2) ref_a[k] = acc;
      acc = s;
    end
    exp_res = acc;
  endtask

  task automatic load_array(input longint vals [DP]);
    for (int k = 0; k < DP; k++) begin
      controlArr          = 1'b1;
      controlArrWEnable_a = 1'b1;
      controlArrAddr_a    = AW'(k);
      controlArrWData_a   = vals[k];
      @(posedge clk);
      #1;
      ref_a[k] = vals[k];
    end
    controlArrWEnable_a = 1'b0;
    controlArr          = 1'b0;
  endtask

  task automatic readback(input string tag, input longint exp [DP]);
    for (int k = 0; k < DP; k++) begin
      controlArr       = 1'b1;
      controlArrAddr_a = AW'(k);
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d]", tag, k), controlArrRData_a, exp[k]);
    end
    controlArr = 1'b0;
  endtask

  task automatic start_run(input int ii, input longint acc0, input logic [1:0] m);
    controlArr          = 1'b0;
    controlArrWEnable_a = 1'b0;
    init_i   = AW'(ii);
    init_acc = acc0;
    mode     = m;
    r_enable = 1'b1;
    @(posedge clk);
    #1;
    r_enable = 1'b0;
  endtask

  // Per-cycle compare from the start edge until done has been held a cycle
  task automatic run_check(input int lat, input string tag);
    for (int k = 0; k <= lat + 1; k++) begin
      @(negedge clk);
      chk($sformatf("%s w_enable@%0d", tag, k), 64'(w_enable), 64'(k >= lat));
      if (k >= lat) begin
        chk($sformatf("%s result@%0d", tag, k), result, exp_res);
        chk($sformatf("%s overflow@%0d", tag, k), 64'(overflow), 64'(exp_ovf));
      end
    end
  endtask

  task automatic s_run(input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] e_res, input logic e_ovf, input string tag);
    s_ctl = 1'b1; s_we = 1'b1;
    s_addr = 2'd0; s_wdata = a0; @(posedge clk); #1;
    s_addr = 2'd1; s_wdata = a1; @(posedge clk); #1;
    s_we = 1'b0; s_ctl = 1'b0;
    s_init_i = 2'd0; s_init_acc = 8'd0; s_mode = 2'd0; s_r_enable = 1'b1;
    @(posedge clk); #1;
    s_r_enable = 1'b0;
    repeat (7) @(negedge clk);
    chk({tag, " w_enable early"}, 64'(s_w_enable), 64'd0);
    @(negedge clk);
    chk({tag, " w_enable"}, 64'(s_w_enable), 64'd1);
    chk({tag, " result"}, 64'(s_result), 64'(e_res));
    chk({tag, " overflow"}, 64'(s_overflow), 64'(e_ovf));
  endtask

  initial begin
    longint v   [DP];
    longint lit [DP];
    int     m;
    int     lat_meas;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; r_enable = 1'b0; init_i = '0; init_acc = '0; mode = '0;
    controlArr = 1'b0; controlArrWEnable_a = 1'b0; controlArrAddr_a = '0; controlArrWData_a = '0;
    s_r_enable = 1'b0; s_init_i = '0; s_init_acc = '0; s_mode = '0;
    s_ctl = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset w_enable", 64'(w_enable), 64'd0);
    chk("reset result", result, 64'd0);
    chk("reset overflow", 64'(overflow), 64'd0);
    chk("reset small w_enable", 64'(s_w_enable), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < DP; k++) v[k] = longint'(k + 1);

    load_array(v);
    model_run(0, 0, 2'd0);
    start_run(0, 0, 2'd0);
    run_check(25, "t1");
    chk("t1 result literal", result, 64'd36);
    readback("t1 array", v);

    load_array(v);
    model_run(0, 10, 2'd1);
    start_run(0, 10, 2'd1);
    run_check(exp_lat, "t2");
    chk("t2 result literal", result, 64'd46);
    lit = '{11, 13, 16, 20, 25, 31, 38, 46};
    readback("t2 array", lit);

    load_array(v);
    model_run(5, 0, 2'd2);
    start_run(5, 0, 2'd2);
    run_check(exp_lat, "t3");
    chk("t3 result literal", result, 64'd21);
    lit = '{1, 2, 3, 4, 5, 0, 6, 13};
    readback("t3 array", lit);

    load_array(v);
    model_run(0, 10, 2'd1);
    start_run(0, 10, 2'd1);
    m = 0;
    repeat (7) begin @(negedge clk); m++; end
    controlArr = 1'b1; controlArrAddr_a = '0;
    repeat (5) begin @(negedge clk); m++; end
    controlArr = 1'b0;
    while (w_enable !== 1'b1 && m < 100) begin @(negedge clk); m++; end
    lat_meas = m - 1;
    n_tests++;
    if (lat_meas < 30 || lat_meas > 32) begin
      n_fail++;
      $display("FAIL t5 latency: got %0d expected 30..32", lat_meas);
    end
    chk("t5 result", result, exp_res);
    chk("t5 result literal", result, 64'd46);
    chk("t5 overflow", 64'(overflow), 64'd0);
    lit = '{11, 13, 16, 20, 25, 31, 38, 46};
    readback("t5 array", lit);

    for (int it = 0; it < 24; it++) begin
      int          ii;
      longint      acc0;
      logic [1:0]  mm;
      for (int k = 0; k < DP; k++) begin
        if ($urandom_range(0, 1) == 1) v[k] = {$urandom, $urandom};
        else v[k] = longint'($urandom_range(0, 400)) - 200;
      end
      ii   = $urandom_range(0, 10);
      acc0 = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) acc0 = longint'($urandom_range(0, 100));
      mm   = 2'($urandom_range(0, 3));
      load_array(v);
      model_run(ii, acc0, mm);
      start_run(ii, acc0, mm);
      run_check(exp_lat, $sformatf("rand%0d", it));
      readback($sformatf("rand%0d array", it), ref_a);
    end

    for (int k = 0; k < DP; k++) v[k] = longint'(k + 1);
    load_array(v);
    start_run(0, 0, 2'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1; r_enable = 1'b1;
    @(negedge clk);
    chk("t6 rst w_enable", 64'(w_enable), 64'd0);
    chk("t6 rst result", result, 64'd0);
    chk("t6 rst overflow", 64'(overflow), 64'd0);
    r_enable = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk("t6 idle w_enable", 64'(w_enable), 64'd0);
    for (int k = 0; k < DP; k++) v[k] = longint'(3 * k + 7);
    load_array(v);
    model_run(DP, 64'h1234, 2'd1);
    start_run(DP, 64'h1234, 2'd1);
    run_check(exp_lat, "t6");
    chk("t6 result literal", result, 64'h1234);
    readback("t6 array", v);

    s_run(8'd100, 8'd100, 8'hC8, 1'b1, "t4 ovf");
    s_run(8'd1, 8'd1, 8'd2, 1'b0, "t4 no ovf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
